// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory-stage load/store unit.
// - Takes the EX/MEM pipeline register outputs and drives the data-memory bus.
// - Steers byte/half/word store data onto the byte lanes.
// - Extracts and extends load data.
// - Stalls the front of the pipeline while the memory inserts wait states.
// - Owns the MEM/WB register, which it loads with write-back data that is
//   already muxed.
//
// Ports
//   clk, rst            pipeline clock, synchronous active-high reset
//   ALU_o_MEM           byte address for loads/stores, otherwise ALU result
//   WD_cut_MEM          store data, low-aligned
//   MemRW_MEM           1 = store
//   RegWEn_MEM          register write enable
//   WBSel_MEM           write-back source: 00 load, 01 ALU, 10 PC+4, 11 zero
//   WordSizeSel_MEM     funct3 size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   Rd_MEM              destination register
//   PCPlusF_MEM         PC+4 of the instruction
//   dmem_req/we/addr/be/wdata   data-memory request side
//   dmem_rdata/ack      data-memory response side
//   stall_MEM           hold PC, IF/ID, ID/EX and EX/MEM
//   RegWEn_WB, Rd_WB, WBdata_WB   MEM/WB register
//   misalign_err        sticky misaligned-access flag
//   bus_err             sticky bus-timeout flag
//
// Configuration
//   MEM_TIMEOUT_EN  when defined, a transfer that stays unacknowledged for
//                   TIMEOUT_CYCLES request cycles is aborted and bus_err is
//                   set. When undefined, the unit waits for dmem_ack
//                   indefinitely and bus_err is tied low.
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_o_MEM,
    input  logic [31:0] WD_cut_MEM,
    input  logic        MemRW_MEM,
    input  logic        RegWEn_MEM,
    input  logic [1:0]  WBSel_MEM,
    input  logic [2:0]  WordSizeSel_MEM,
    input  logic [4:0]  Rd_MEM,
    input  logic [8:0]  PCPlusF_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_MEM,
    output logic        RegWEn_WB,
    output logic [4:0]  Rd_WB,
    output logic [31:0] WBdata_WB,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    state_t      state;
    state_t      state_next;

    logic [1:0]  size_p0;
    logic [1:0]  off_p0;
    logic        is_load_p0;
    logic        is_store_p0;
    logic        mem_op_p0;
    logic        misaligned_p0;
    logic        access_p0;
    logic        abort;
    logic [31:0] load_data_p0;
    logic [31:0] wb_value_p0;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane it could land on, so the byte
    // enables alone pick the target bytes.
    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] data;
        case (sz)
            SZ_B:    data = {4{wd[7:0]}};
            SZ_H:    data = {2{wd[15:0]}};
            default: data = wd;
        endcase
        return data;
    endfunction

    // Select the addressed byte/half of the read word and extend it.
    // sz_code[2] set means an unsigned (zero-extending) load.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  sz_code);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic        [31:0] result;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h   = off[1] ? rdata[31:16] : rdata[15:0];
        b_s = b;
        h_s = h;
        case (sz_code[1:0])
            SZ_B:    result = sz_code[2] ? {24'b0, b} : 32'(b_s);
            SZ_H:    result = sz_code[2] ? {16'b0, h} : 32'(h_s);
            default: result = rdata;
        endcase
        return result;
    endfunction

    // ---- stage p0: decode of the EX/MEM register contents ----
    assign size_p0       = WordSizeSel_MEM[1:0];
    assign off_p0        = ALU_o_MEM[1:0];
    assign is_load_p0    = (WBSel_MEM == 2'b00) && RegWEn_MEM;
    assign is_store_p0   = MemRW_MEM;
    assign mem_op_p0     = is_load_p0 || is_store_p0;
    // Size code 11 is treated as a word, so it needs full alignment.
    assign misaligned_p0 = mem_op_p0 &&
                           (((size_p0 == SZ_H) && off_p0[0]) ||
                            ((size_p0[1]) && (off_p0 != 2'b00)));
    assign access_p0     = mem_op_p0 && !misaligned_p0;

    assign dmem_addr    = {ALU_o_MEM[31:2], 2'b00};
    assign dmem_wdata   = store_wdata(size_p0, WD_cut_MEM);
    assign load_data_p0 = load_extend(dmem_rdata, off_p0, WordSizeSel_MEM);

    always_comb begin
        case (WBSel_MEM)
            2'b00:   wb_value_p0 = load_data_p0;
            2'b01:   wb_value_p0 = ALU_o_MEM;
            2'b10:   wb_value_p0 = {23'b0, PCPlusF_MEM};
            default: wb_value_p0 = 32'b0;
        endcase
    end

    // ---- bus FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- bus FSM: next state ----
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Request dropping in WAIT only happens if the upstream
                // registers were not held; fall back to IDLE in that case.
                if (dmem_ack || abort || !dmem_req) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---- bus FSM: outputs ----
    // The request depends only on the held EX/MEM contents, so IDLE and WAIT
    // present identical addr/be/wdata/we for the whole transfer.
    always_comb begin
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        dmem_be  = 4'b0000;
        if (!rst && access_p0) begin
            dmem_req = 1'b1;
            dmem_we  = is_store_p0;
            dmem_be  = is_store_p0 ? store_be(size_p0, off_p0) : 4'b1111;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Counts request cycles of the current transfer that went unacknowledged.
    logic [CNT_W-1:0] wait_cnt;
    logic             bus_err_q;

    // An ack in the final cycle still completes the transfer.
    assign abort = (state == S_WAIT) && !dmem_ack && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next == S_WAIT) begin
            wait_cnt <= (state == S_IDLE) ? CNT_W'(1) : wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (abort) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    // Without the timeout the parameter has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign stall_MEM = dmem_req && !dmem_ack && !abort;

    // ---- stage p1: MEM/WB register ----
    // Stalled, aborted and misaligned cycles all become bubbles; the data
    // fields hold so a bubble does not disturb forwarding paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWEn_WB <= 1'b0;
            Rd_WB     <= 5'b0;
            WBdata_WB <= 32'b0;
        end else if (stall_MEM || abort || misaligned_p0) begin
            RegWEn_WB <= 1'b0;
        end else begin
            RegWEn_WB <= RegWEn_MEM;
            Rd_WB     <= Rd_MEM;
            WBdata_WB <= wb_value_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (misaligned_p0) begin
            misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_o_MEM;
    logic [31:0] WD_cut_MEM;
    logic        MemRW_MEM;
    logic        RegWEn_MEM;
    logic [1:0]  WBSel_MEM;
    logic [2:0]  WordSizeSel_MEM;
    logic [4:0]  Rd_MEM;
    logic [8:0]  PCPlusF_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_MEM;
    logic        RegWEn_WB;
    logic [4:0]  Rd_WB;
    logic [31:0] WBdata_WB;
    logic        misalign_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: the MEM/WB contents and flags as they must be.
    bit          m_ready = 1'b0;
    logic        m_wen = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    logic        m_merr = 1'b0;
    logic        m_berr = 1'b0;
    int          m_waited = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ALU_o_MEM(ALU_o_MEM), .WD_cut_MEM(WD_cut_MEM),
        .MemRW_MEM(MemRW_MEM), .RegWEn_MEM(RegWEn_MEM),
        .WBSel_MEM(WBSel_MEM), .WordSizeSel_MEM(WordSizeSel_MEM),
        .Rd_MEM(Rd_MEM), .PCPlusF_MEM(PCPlusF_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_MEM(stall_MEM),
        .RegWEn_WB(RegWEn_WB), .Rd_WB(Rd_WB), .WBdata_WB(WBdata_WB),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bus-side behaviour of the current inputs.
    function automatic void model_comb(output logic req, output logic we,
                                       output logic [3:0] be, output logic [31:0] wdata,
                                       output logic stall, output logic abort);
        int   sz;
        int   off;
        logic ld;
        logic st;
        logic mis;
        sz  = int'(WordSizeSel_MEM[1:0]);
        off = int'(ALU_o_MEM[1:0]);
        ld  = (WBSel_MEM == 2'b00) && RegWEn_MEM;
        st  = MemRW_MEM;
        mis = (ld || st) && ((sz == 1 && (off % 2) == 1) || (sz >= 2 && off != 0));
        req = !rst && (ld || st) && !mis;
        we  = req && st;
        be  = 4'h0;
        if (req) begin
            if (!st)          be = 4'hF;
            else if (sz == 0) be = 4'(1 << off);
            else if (sz == 1) be = (off >= 2) ? 4'hC : 4'h3;
            else              be = 4'hF;
        end
        if (sz == 0)      wdata = {4{WD_cut_MEM[7:0]}};
        else if (sz == 1) wdata = {2{WD_cut_MEM[15:0]}};
        else              wdata = WD_cut_MEM;
        abort = TO_EN && req && !dmem_ack && (m_waited == TO - 1);
        stall = req && !dmem_ack && !abort;
    endfunction

    function automatic logic model_mis();
        logic ld;
        ld = (WBSel_MEM == 2'b00) && RegWEn_MEM;
        return (ld || MemRW_MEM) &&
               ((WordSizeSel_MEM[1:0] == 2'b01 && ALU_o_MEM[0]) ||
                (WordSizeSel_MEM[1] && ALU_o_MEM[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] model_wb();
        logic [31:0] sh;
        logic [31:0] v;
        sh = dmem_rdata >> (8 * int'(ALU_o_MEM[1:0]));
        case (WBSel_MEM)
            2'b00: begin
                if (WordSizeSel_MEM[1:0] == 2'b00) begin
                    v = sh & 32'h0000_00FF;
                    if (!WordSizeSel_MEM[2] && v[7]) v = v | 32'hFFFF_FF00;
                end else if (WordSizeSel_MEM[1:0] == 2'b01) begin
                    v = sh & 32'h0000_FFFF;
                    if (!WordSizeSel_MEM[2] && v[15]) v = v | 32'hFFFF_0000;
                end else begin
                    v = dmem_rdata;
                end
            end
            2'b01:   v = ALU_o_MEM;
            2'b10:   v = 32'(PCPlusF_MEM);
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Compare process: checks outputs every falling edge, then advances the
    // model to what the coming rising edge must produce.
    initial begin
        logic        e_req, e_we, e_stall, e_abort, e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        forever begin
            @(negedge clk);
            model_comb(e_req, e_we, e_be, e_wd, e_stall, e_abort);
            e_mis = model_mis();
            check("dmem_req", dmem_req, e_req);
            check("stall_MEM", stall_MEM, e_stall);
            check("dmem_addr", dmem_addr, {ALU_o_MEM[31:2], 2'b00});
            if (e_req || rst) begin
                check("dmem_we", dmem_we, e_we);
                check("dmem_be", dmem_be, e_be);
            end
            if (e_req && e_we) check("dmem_wdata", dmem_wdata, e_wd);
            if (m_ready) begin
                check("RegWEn_WB", RegWEn_WB, m_wen);
                check("Rd_WB", Rd_WB, m_rd);
                check("WBdata_WB", WBdata_WB, m_data);
                check("misalign_err", misalign_err, m_merr);
                check("bus_err", bus_err, m_berr);
            end
            if (rst) begin
                m_wen = 0; m_rd = 0; m_data = 0; m_merr = 0; m_berr = 0;
                m_waited = 0; m_ready = 1'b1;
            end else begin
                if (e_mis) m_merr = 1'b1;
                if (e_abort) m_berr = 1'b1;
                if (e_stall) begin
                    m_wen = 1'b0;
                    m_waited++;
                end else begin
                    m_waited = 0;
                    if (e_abort || e_mis) begin
                        m_wen = 1'b0;
                    end else begin
                        m_wen  = RegWEn_MEM;
                        m_rd   = Rd_MEM;
                        m_data = model_wb();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input logic memrw, input logic regwen, input logic [1:0] wbsel,
                          input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [8:0] pc);
        MemRW_MEM = memrw; RegWEn_MEM = regwen; WBSel_MEM = wbsel;
        WordSizeSel_MEM = sz; ALU_o_MEM = addr; WD_cut_MEM = wd;
        Rd_MEM = rd; PCPlusF_MEM = pc;
    endtask

    task automatic set_nop();
        set_op(1'b0, 1'b0, 2'b11, 3'b010, 32'h0, 32'h0, 5'd0, 9'd0);
        dmem_ack = 1'b0;
    endtask

    // Holds the current instruction while stalled; ack_at = 0 means never ack.
    task automatic run_xfer(input int ack_at, input int budget, output int stalls, output bit done);
        stalls = 0;
        done   = 1'b0;
        for (int c = 1; c <= budget && !done; c++) begin
            dmem_ack = (c == ack_at);
            @(negedge clk);
            if (stall_MEM) stalls++;
            else done = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        int stalls;
        bit done;
        rst = 1'b1;
        dmem_rdata = 32'h0;
        set_nop();
        tick(); tick();
        rst = 1'b0;

        // Reset arriving in the middle of a waiting transfer.
        set_op(1'b0, 1'b1, 2'b00, 3'b010, 32'h100, 32'h0, 5'd3, 9'd0);
        settle();
        check("lit_wait_stall", stall_MEM, 1);
        tick(); tick();
        rst = 1'b1;
        settle();
        check("lit_rst_req", dmem_req, 0);
        check("lit_rst_be", dmem_be, 0);
        tick(); tick();
        rst = 1'b0;
        set_nop();
        settle();
        check("lit_rst_wen", RegWEn_WB, 0);
        check("lit_rst_wbdata", WBdata_WB, 0);
        check("lit_rst_flags", {misalign_err, bus_err}, 0);

        // LB / LBU, zero wait states.
        set_op(1'b0, 1'b1, 2'b00, 3'b000, 32'h103, 32'h0, 5'd5, 9'd0);
        dmem_rdata = 32'h80FF_0000;
        dmem_ack = 1'b1;
        settle();
        check("lit_lb_be", dmem_be, 4'hF);
        tick();
        set_nop();
        settle();
        check("lit_lb_wen", RegWEn_WB, 1);
        check("lit_lb_data", WBdata_WB, 32'hFFFF_FF80);
        tick();
        set_op(1'b0, 1'b1, 2'b00, 3'b100, 32'h103, 32'h0, 5'd5, 9'd0);
        dmem_ack = 1'b1;
        tick();
        set_nop();
        settle();
        check("lit_lbu_data", WBdata_WB, 32'h0000_0080);
        tick();

        // SH with three wait states.
        set_op(1'b1, 1'b0, 2'b01, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0, 9'd0);
        settle();
        check("lit_sh_be", dmem_be, 4'hC);
        check("lit_sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        run_xfer(4, 10, stalls, done);
        set_nop();
        check("lit_sh_done", done, 1);
        check("lit_sh_stalls", stalls, 3);
        settle();
        check("lit_sh_wen", RegWEn_WB, 0);

        // Misaligned LW: flag, bubble, no request.
        set_op(1'b0, 1'b1, 2'b00, 3'b010, 32'h105, 32'h0, 5'd9, 9'd0);
        settle();
        check("lit_mis_req", dmem_req, 0);
        check("lit_mis_stall", stall_MEM, 0);
        tick();
        set_nop();
        settle();
        check("lit_mis_flag", misalign_err, 1);
        check("lit_mis_wen", RegWEn_WB, 0);
        tick(); tick();
        check("lit_mis_sticky", misalign_err, 1);

        // Misaligned SW with RegWEn=0: flag only, no stall.
        set_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h2, 32'h5555_AAAA, 5'd0, 9'd0);
        settle();
        check("lit_missw_stall", stall_MEM, 0);
        tick();

        // SB at offset 1, zero wait.
        set_op(1'b1, 1'b0, 2'b01, 3'b000, 32'h201, 32'h0000_00AB, 5'd0, 9'd0);
        dmem_ack = 1'b1;
        settle();
        check("lit_sb_be", dmem_be, 4'b0010);
        check("lit_sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        tick();

        // LW with a missing ack: timeout abort, or a late ack at cycle 20.
        set_op(1'b0, 1'b1, 2'b00, 3'b010, 32'h300, 32'h0, 5'd11, 9'd0);
        dmem_rdata = 32'h0BAD_F00D;
        run_xfer(TO_EN ? 0 : 20, 40, stalls, done);
        set_nop();
        check("lit_to_done", done, 1);
        settle();
        if (TO_EN) begin
            check("lit_to_stalls", stalls, 3);
            check("lit_to_buserr", bus_err, 1);
            check("lit_to_wen", RegWEn_WB, 0);
        end else begin
            check("lit_noto_stalls", stalls, 19);
            check("lit_noto_wen", RegWEn_WB, 1);
            check("lit_noto_data", WBdata_WB, 32'h0BAD_F00D);
            check("lit_noto_buserr", bus_err, 0);
        end

        // ALU result, then JAL link value; a stray ack must be ignored.
        set_op(1'b0, 1'b1, 2'b01, 3'b010, 32'hDEAD_BEEF, 32'h0, 5'd7, 9'd0);
        dmem_ack = 1'b1;
        settle();
        check("lit_alu_req", dmem_req, 0);
        tick();
        set_op(1'b0, 1'b1, 2'b10, 3'b010, 32'h0, 32'h0, 5'd1, 9'h1F4);
        settle();
        check("lit_alu_data", WBdata_WB, 32'hDEAD_BEEF);
        check("lit_alu_rd", Rd_WB, 7);
        tick();
        set_op(1'b0, 1'b1, 2'b11, 3'b010, 32'h1234_5678, 32'h0, 5'd4, 9'h0FF);
        settle();
        check("lit_jal_data", WBdata_WB, 32'h0000_01F4);
        tick();
        set_nop();
        settle();
        check("lit_zero_data", WBdata_WB, 32'h0);
        check("lit_zero_wen", RegWEn_WB, 1);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
